// File: rtl/multicycle_control.sv
// Multicycle RV32I main control: instruction-sequencing FSM plus decode of
// datapath selects, write enables, ALU operation and immediate format.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic       IllegalOp
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11
    } state_t;

    state_t     state, state_next;
    logic       pc_write, mem_write, ir_write, reg_write, illegal;
    logic [2:0] alu_decoded;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so the register samples the pre-edge next-state value.
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        alu_decoded = ALU_ADD;
        case (funct3)
            3'b000:  if (op[5] && funct7b5) alu_decoded = ALU_SUB;
            3'b010:  alu_decoded = ALU_SLT;
            3'b110:  alu_decoded = ALU_OR;
            3'b111:  alu_decoded = ALU_AND;
            default: alu_decoded = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE: ImmSrc = 3'b001;
            OP_BEQ:   ImmSrc = 3'b010;
            OP_JAL:   ImmSrc = 3'b011;
            OP_LUI:   ImmSrc = 3'b100;
            default:  ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        // NOTE: every output is given a default first so no path can infer a latch.
        state_next = FETCH;
        pc_write   = 1'b0;
        AdrSrc     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECUTER;
                    OP_ITYPE:          state_next = EXECUTEI;
                    OP_BEQ:            state_next = BEQ;
                    OP_JAL:            state_next = JAL;
                    OP_LUI:            state_next = LUI;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decoded;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decoded;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pc_write   = Zero;
                state_next = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write   = 1'b1;
                state_next = ALUWB;
            end
            LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                state_next = ALUWB;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset overrides every enable so an interrupted write-back or store never commits.
    assign PCWrite   = pc_write  & ~reset;
    assign MemWrite  = mem_write & ~reset;
    assign IRWrite   = ir_write  & ~reset;
    assign RegWrite  = reg_write & ~reset;
    assign IllegalOp = illegal   & ~reset;
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction step model of the
// expected control word plus hand-computed spot checks.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .IllegalOp(IllegalOp)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic       reg_write;
        logic [2:0] imm;
        logic       illegal;
    } ctrl_t;

    int    pass_count  = 0;
    int    check_count = 0;
    ctrl_t exp_ctrl;
    ctrl_t act_ctrl;
    ctrl_t obs [8];
    logic  exp_valid = 1'b0;
    logic  in_reset  = 1'b0;
    logic  excl;
    int    cur_step  = 0;
    string cur_name  = "";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Cycles per instruction counted from its FETCH cycle.
    function automatic int cpi(input logic [6:0] o);
        case (o)
            7'b0000011:                                     return 5;
            7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b0110111:                         return 4;
            7'b1100011:                                     return 3;
            default:                                        return 2;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word for step number 'step' of an instruction.
    function automatic ctrl_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                    input logic z, input int step);
        ctrl_t c = '0;
        c.imm = imm_of(o);
        if (step == 0) begin
            c.ir_write = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10; c.pc_write = 1'b1;
        end else if (step == 1) begin
            c.src_a = 2'b01; c.src_b = 2'b01; c.illegal = (cpi(o) == 2);
        end else begin
            case (o)
                7'b0000011: begin
                    if (step == 2)      begin c.src_a = 2'b10; c.src_b = 2'b01; end
                    else if (step == 3) c.adr_src = 1'b1;
                    else                begin c.result_src = 2'b01; c.reg_write = 1'b1; end
                end
                7'b0100011: begin
                    if (step == 2) begin c.src_a = 2'b10; c.src_b = 2'b01; end
                    else           begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
                end
                7'b0110011, 7'b0010011: begin
                    if (step == 2) begin
                        c.src_a = 2'b10;
                        c.src_b = (o == 7'b0010011) ? 2'b01 : 2'b00;
                        c.alu   = alu_of(o, f3, f7);
                    end else c.reg_write = 1'b1;
                end
                7'b1100011: begin
                    c.src_a = 2'b10; c.alu = 3'b001; c.pc_write = z;
                end
                7'b1101111: begin
                    if (step == 2) begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
                    else           c.reg_write = 1'b1;
                end
                default: begin
                    if (step == 2) begin c.src_a = 2'b11; c.src_b = 2'b01; end
                    else           c.reg_write = 1'b1;
                end
            endcase
        end
        return c;
    endfunction

    function automatic ctrl_t reset_mask();
        ctrl_t m = '0;
        m.pc_write = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1;
        m.reg_write = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            act_ctrl.pc_write   = PCWrite;
            act_ctrl.adr_src    = AdrSrc;
            act_ctrl.mem_write  = MemWrite;
            act_ctrl.ir_write   = IRWrite;
            act_ctrl.result_src = ResultSrc;
            act_ctrl.src_a      = ALUSrcA;
            act_ctrl.src_b      = ALUSrcB;
            act_ctrl.alu        = ALUControl;
            act_ctrl.reg_write  = RegWrite;
            act_ctrl.imm        = ImmSrc;
            act_ctrl.illegal    = IllegalOp;
            if (in_reset) act_ctrl = ctrl_t'(act_ctrl & reset_mask());
            check($sformatf("%s step%0d control word", cur_name, cur_step),
                  32'(act_ctrl), 32'(exp_ctrl));
            excl = (32'(MemWrite) + 32'(RegWrite) + 32'(IRWrite)) <= 32'd1;
            check($sformatf("%s step%0d write exclusivity", cur_name, cur_step), 32'(excl), 32'd1);
            obs[cur_step] = act_ctrl;
        end
    end

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int rst_step);
        int n = cpi(o);
        for (int i = 0; i < 8; i++) obs[i] = '0;
        for (int s = 0; s < n; s++) begin
            @(posedge clk); #1;
            op = o; funct3 = f3; funct7b5 = f7;
            Zero = (n == 3 && s == 2) ? z : logic'(s[0]);
            cur_name = name; cur_step = s;
            if (s == rst_step) begin
                reset = 1'b1; in_reset = 1'b1; exp_ctrl = '0;
            end else begin
                reset = 1'b0; in_reset = 1'b0; exp_ctrl = model(o, f3, f7, Zero, s);
            end
            exp_valid = 1'b1;
            if (s == rst_step) break;
        end
        @(negedge clk); #1;
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            reset = 1'b1; in_reset = 1'b1; exp_ctrl = '0;
            cur_name = "reset"; cur_step = 0; exp_valid = 1'b1;
        end
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; Zero = 1'b0;
        reset_cycles(2);

        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        check("lw fetch IRWrite", 32'(obs[0].ir_write), 32'd1);
        check("lw memwb ResultSrc", 32'(obs[4].result_src), 32'd1);
        check("lw memwb RegWrite", 32'(obs[4].reg_write), 32'd1);
        check("lw memadr ImmSrc", 32'(obs[2].imm), 32'd0);

        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, -1);
        check("sw MemWrite", 32'(obs[3].mem_write), 32'd1);
        check("sw AdrSrc", 32'(obs[3].adr_src), 32'd1);
        check("sw ImmSrc", 32'(obs[3].imm), 32'd1);

        run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, -1);
        check("add ALUControl", 32'(obs[2].alu), 32'd0);
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        check("sub ALUControl", 32'(obs[2].alu), 32'd1);
        run_instr("slt", 7'b0110011, 3'b010, 1'b0, 1'b0, -1);
        check("slt ALUControl", 32'(obs[2].alu), 32'd5);
        run_instr("and", 7'b0110011, 3'b111, 1'b0, 1'b0, -1);
        check("and ALUControl", 32'(obs[2].alu), 32'd2);
        run_instr("ori", 7'b0010011, 3'b110, 1'b0, 1'b0, -1);
        check("ori ALUControl", 32'(obs[2].alu), 32'd3);
        check("ori ALUSrcB", 32'(obs[2].src_b), 32'd1);
        run_instr("addi f7b5", 7'b0010011, 3'b000, 1'b1, 1'b0, -1);
        check("addi f7b5 ALUControl", 32'(obs[2].alu), 32'd0);

        run_instr("beq taken", 7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        check("beq taken PCWrite", 32'(obs[2].pc_write), 32'd1);
        check("beq ALUControl", 32'(obs[2].alu), 32'd1);
        check("beq ImmSrc", 32'(obs[2].imm), 32'd2);
        run_instr("beq not taken", 7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        check("beq not taken PCWrite", 32'(obs[2].pc_write), 32'd0);

        run_instr("jal", 7'b1101111, 3'b111, 1'b1, 1'b0, -1);
        check("jal PCWrite", 32'(obs[2].pc_write), 32'd1);
        check("jal ALUControl", 32'(obs[2].alu), 32'd0);
        check("jal wb RegWrite", 32'(obs[3].reg_write), 32'd1);
        check("jal ImmSrc", 32'(obs[3].imm), 32'd3);
        run_instr("lui", 7'b0110111, 3'b000, 1'b0, 1'b0, -1);
        check("lui ALUSrcA", 32'(obs[2].src_a), 32'd3);
        check("lui ImmSrc", 32'(obs[2].imm), 32'd4);

        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, -1);
        check("illegal IllegalOp", 32'(obs[1].illegal), 32'd1);

        run_instr("sw reset", 7'b0100011, 3'b000, 1'b0, 1'b0, 3);
        check("sw reset MemWrite", 32'(obs[3].mem_write), 32'd0);
        reset_cycles(1);
        run_instr("add reset", 7'b0110011, 3'b000, 1'b0, 1'b0, 3);
        check("add reset RegWrite", 32'(obs[3].reg_write), 32'd0);
        reset_cycles(1);
        run_instr("illegal reset", 7'b1111111, 3'b000, 1'b0, 1'b0, 1);
        check("illegal reset IllegalOp", 32'(obs[1].illegal), 32'd0);
        reset_cycles(1);
        run_instr("lw after reset", 7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        check("lw after reset RegWrite", 32'(obs[4].reg_write), 32'd1);

        exp_valid = 1'b0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
